// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one downstream bus master port among N_MASTERS harts.
// Optional feature macro: ARVI_ARB_LOCK_EN adds i_m_atomic and a LOCKED state for indivisible RMW.
`ifndef XLEN
`define XLEN 32
`endif

module bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int XLEN      = `XLEN
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_MASTERS-1:0]      i_m_bus_en,
  input  logic [N_MASTERS-1:0]      i_m_wr_en,
  input  logic [N_MASTERS*XLEN-1:0] i_m_addr,
  input  logic [N_MASTERS*XLEN-1:0] i_m_wr_data,
  input  logic [N_MASTERS*4-1:0]    i_m_byte_en,
`ifdef ARVI_ARB_LOCK_EN
  input  logic [N_MASTERS-1:0]      i_m_atomic,
`endif
  output logic [N_MASTERS-1:0]      o_m_ack,
  output logic [XLEN-1:0]           o_m_rd_data,
  output logic                      o_bus_en,
  output logic                      o_wr_en,
  output logic [XLEN-1:0]           o_addr,
  output logic [XLEN-1:0]           o_wr_data,
  output logic [3:0]                o_byte_en,
  input  logic                      i_ack,
  input  logic [XLEN-1:0]           i_rd_data,
  output logic [N_MASTERS-1:0]      o_grant
);

  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

`ifdef ARVI_ARB_LOCK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_LOCKED = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1} state_t;
`endif

  state_t                state_q, state_d;
  logic [N_MASTERS-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  owner_req_s;
  logic [PW-1:0]         owner_idx_s;

  // First requester at or after ptr, wrapping; returned one-hot.
  function automatic logic [N_MASTERS-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                   input logic [PW-1:0] ptr);
    logic [N_MASTERS-1:0] sel;
    logic                 found;
    int                   idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = (int'(ptr) + k) % N_MASTERS;
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  function automatic logic [PW-1:0] oh_to_idx(input logic [N_MASTERS-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = idx | ({PW{oh[k]}} & PW'(k));
    end
    return idx;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
    logic [PW-1:0] nxt;
    if (int'(idx) == N_MASTERS - 1) begin
      nxt = '0;
    end else begin
      nxt = idx + PW'(1);
    end
    return nxt;
  endfunction

  assign owner_req_s = |(i_m_bus_en & gnt_q);
  assign owner_idx_s = oh_to_idx(gnt_q);
  assign o_grant     = gnt_q;

`ifdef ARVI_ARB_LOCK_EN
  logic owner_atomic_s;
  assign owner_atomic_s = |(i_m_atomic & gnt_q);
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state, grant and pointer update.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|i_m_bus_en) begin
          gnt_d   = rr_pick(i_m_bus_en, rr_ptr_q);
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (i_ack) begin
`ifdef ARVI_ARB_LOCK_EN
          if (owner_atomic_s) begin
            state_d = S_LOCKED;
          end else begin
            rr_ptr_d = ptr_after(owner_idx_s);
            gnt_d    = '0;
            state_d  = S_IDLE;
          end
`else
          rr_ptr_d = ptr_after(owner_idx_s);
          gnt_d    = '0;
          state_d  = S_IDLE;
`endif
        end else if (!owner_req_s) begin
          // Owner abandoned the request: drop it without advancing fairness.
          gnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_BUSY;
        end
      end
`ifdef ARVI_ARB_LOCK_EN
      S_LOCKED: begin
        if (owner_req_s) begin
          state_d = S_BUSY;
        end else if (!owner_atomic_s) begin
          rr_ptr_d = ptr_after(owner_idx_s);
          gnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          state_d = S_LOCKED;
        end
      end
`endif
      default: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        rr_ptr_d = '0;
      end
    endcase
  end

  // Downstream mux and upstream response, live only while a transfer is in BUSY.
  always_comb begin
    o_bus_en    = 1'b0;
    o_wr_en     = 1'b0;
    o_addr      = '0;
    o_wr_data   = '0;
    o_byte_en   = 4'b0000;
    o_m_ack     = '0;
    o_m_rd_data = '0;
    if (state_q == S_BUSY) begin
      for (int k = 0; k < N_MASTERS; k++) begin
        o_bus_en  = o_bus_en  | (gnt_q[k] & i_m_bus_en[k]);
        o_wr_en   = o_wr_en   | (gnt_q[k] & i_m_wr_en[k]);
        o_addr    = o_addr    | ({XLEN{gnt_q[k]}} & i_m_addr[k*XLEN +: XLEN]);
        o_wr_data = o_wr_data | ({XLEN{gnt_q[k]}} & i_m_wr_data[k*XLEN +: XLEN]);
        o_byte_en = o_byte_en | ({4{gnt_q[k]}} & i_m_byte_en[k*4 +: 4]);
      end
      o_m_ack     = gnt_q & {N_MASTERS{i_ack}};
      o_m_rd_data = i_rd_data;
    end else begin
      o_m_ack     = '0;
      o_m_rd_data = '0;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: each issued transaction pushes its expected downstream
// view and response; every observed upstream ack pops and compares one entry.
module tb_bus_arbiter;
  localparam int N  = 2;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_bus_en, m_wr_en;
  logic [N*XL-1:0] m_addr, m_wr_data;
  logic [N*4-1:0]  m_byte_en;
`ifdef ARVI_ARB_LOCK_EN
  logic [N-1:0]    m_atomic;
`endif
  logic [N-1:0]    m_ack;
  logic [XL-1:0]   m_rd_data;
  logic            bus_en, wr_en;
  logic [XL-1:0]   addr, wr_data;
  logic [3:0]      byte_en;
  logic            ack;
  logic [XL-1:0]   rd_data;
  logic [N-1:0]    grant;

  always #5 clk = ~clk;

  bus_arbiter #(.N_MASTERS(N), .XLEN(XL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m_bus_en(m_bus_en), .i_m_wr_en(m_wr_en), .i_m_addr(m_addr),
    .i_m_wr_data(m_wr_data), .i_m_byte_en(m_byte_en),
`ifdef ARVI_ARB_LOCK_EN
    .i_m_atomic(m_atomic),
`endif
    .o_m_ack(m_ack), .o_m_rd_data(m_rd_data),
    .o_bus_en(bus_en), .o_wr_en(wr_en), .o_addr(addr), .o_wr_data(wr_data),
    .o_byte_en(byte_en), .i_ack(ack), .i_rd_data(rd_data), .o_grant(grant)
  );

  typedef struct {
    logic [N-1:0]  ack;
    logic [XL-1:0] addr;
    logic          wr;
    logic [XL-1:0] wdata;
    logic [3:0]    be;
    logic [XL-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  int prev_ack_cyc = -1;
  bit per_chk = 1'b0;
  int lat = 1;
  int lat_cnt = 0;
  bit resp_en = 1'b1;
  bit stray_ack = 1'b0;
  int rem[N];
  int n_acks[N];
  logic [N-1:0] acked_prev;
  bit nxt_v[N];
  logic nxt_wr[N];
  logic [XL-1:0] nxt_addr[N], nxt_wd[N];
  logic [3:0] nxt_be[N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XL-1:0] mem_rd(input logic [XL-1:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic set_master(input int i, input logic wr, input logic [XL-1:0] a,
                            input logic [XL-1:0] wd, input logic [3:0] be);
    m_wr_en[i]             = wr;
    m_addr[i*XL +: XL]     = a;
    m_wr_data[i*XL +: XL]  = wd;
    m_byte_en[i*4 +: 4]    = be;
  endtask

  task automatic push_exp(input int i, input logic wr, input logic [XL-1:0] a,
                          input logic [XL-1:0] wd, input logic [3:0] be);
    exp_t e;
    e.ack    = '0;
    e.ack[i] = 1'b1;
    e.addr   = a;
    e.wr     = wr;
    e.wdata  = wd;
    e.be     = be;
    e.rdata  = wr ? 32'h0 : mem_rd(a);
    sb.push_back(e);
  endtask

  // One clock: masters react to last cycle's ack, responder drives, then sample.
  task automatic step();
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (acked_prev[k]) begin
        if (rem[k] > 0) rem[k]--;
        if (rem[k] == 0) begin
          m_bus_en[k] = 1'b0;
`ifdef ARVI_ARB_LOCK_EN
          m_atomic[k] = 1'b0;
`endif
        end else if (nxt_v[k]) begin
          set_master(k, nxt_wr[k], nxt_addr[k], nxt_wd[k], nxt_be[k]);
          nxt_v[k] = 1'b0;
        end
      end
    end
    acked_prev = '0;
    ack = 1'b0;
    rd_data = $urandom();
    if (stray_ack) begin
      ack = 1'b1;
      stray_ack = 1'b0;
      lat_cnt = 0;
    end else if (bus_en && resp_en) begin
      if (lat_cnt >= lat) begin
        ack = 1'b1;
        lat_cnt = 0;
        rd_data = mem_rd(addr);
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
    #2;
    cyc++;
    if (m_ack != '0) begin
      last_ack_cyc = cyc;
      if (sb.size() == 0) begin
        check_eq("unexpected_ack", 64'(m_ack), 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("ack_vec", 64'(m_ack), 64'(e.ack));
        check_eq("grant_vs_ack", 64'(grant), 64'(e.ack));
        check_eq("ds_addr", 64'(addr), 64'(e.addr));
        check_eq("ds_wr_en", 64'(wr_en), 64'(e.wr));
        check_eq("ds_wdata", 64'(wr_data), 64'(e.wdata));
        check_eq("ds_be", 64'(byte_en), 64'(e.be));
        if (!e.wr) check_eq("rd_data", 64'(m_rd_data), 64'(e.rdata));
        for (int k = 0; k < N; k++) if (m_ack[k]) n_acks[k]++;
        if (per_chk) begin
          if (prev_ack_cyc >= 0) check_eq("txn_cycles", 64'(cyc - prev_ack_cyc), 64'd3);
          prev_ack_cyc = cyc;
        end
      end
      acked_prev = m_ack;
    end
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      step();
      n++;
    end
    check_eq(tag, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rise_cyc;
    rst = 1'b1;
    m_bus_en = '0; m_wr_en = '0; m_addr = '0; m_wr_data = '0; m_byte_en = '0;
`ifdef ARVI_ARB_LOCK_EN
    m_atomic = '0;
`endif
    ack = 1'b0; rd_data = 32'h0; acked_prev = '0;
    for (int k = 0; k < N; k++) begin
      rem[k] = 0; n_acks[k] = 0; nxt_v[k] = 1'b0;
    end

    // Reset state
    step(); step();
    check_eq("rst_grant", 64'(grant), 64'd0);
    check_eq("rst_bus_en", 64'(bus_en), 64'd0);
    check_eq("rst_m_ack", 64'(m_ack), 64'd0);
    check_eq("rst_addr", 64'(addr), 64'd0);
    check_eq("rst_rd_data", 64'(m_rd_data), 64'd0);
    rst = 1'b0;

    // Single master read, ack 3 cycles after o_bus_en
    lat = 3;
    set_master(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    push_exp(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    rem[0] = 1; m_bus_en[0] = 1'b1;
    step();
    check_eq("t1_grant_latency", 64'(bus_en), 64'd1);
    check_eq("t1_grant", 64'(grant), 64'd1);
    rise_cyc = cyc;
    drain("t1_drain", 20);
    check_eq("t1_ack_cycle", 64'(last_ack_cyc - rise_cyc), 64'd3);
    step();
    check_eq("t1_grant_after", 64'(grant), 64'd0);

    // Abort by master 1, stray ack in IDLE, rr_ptr must stay at 1
    resp_en = 1'b0;
    set_master(1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
    rem[1] = 1; m_bus_en[1] = 1'b1;
    step();
    check_eq("t4_grant", 64'(grant), 64'd2);
    step();
    check_eq("t4_bus_en", 64'(bus_en), 64'd1);
    m_bus_en[1] = 1'b0; rem[1] = 0;
    step();
    check_eq("t4_abort_grant", 64'(grant), 64'd0);
    stray_ack = 1'b1;
    step();
    check_eq("t4_stray_ack", 64'(m_ack), 64'd0);
    check_eq("t4_stray_rd", 64'(m_rd_data), 64'd0);
    resp_en = 1'b1; lat = 1;
    set_master(0, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
    set_master(1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
    push_exp(1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
    push_exp(0, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
    rem[0] = 1; rem[1] = 1; m_bus_en = 2'b11;
    drain("t4_drain", 30);

    // Contention from reset: strict alternation, 3 cycles per transaction
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_master(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    set_master(1, 1'b0, 32'h0000_1100, 32'h0, 4'hF);
    for (int t = 0; t < 20; t++) begin
      if (t % 2 == 0) push_exp(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
      else            push_exp(1, 1'b0, 32'h0000_1100, 32'h0, 4'hF);
    end
    n_acks[0] = 0; n_acks[1] = 0;
    rem[0] = 10; rem[1] = 10;
    per_chk = 1'b1; prev_ack_cyc = -1;
    m_bus_en = 2'b11;
    drain("t2_drain", 100);
    per_chk = 1'b0;
    check_eq("t2_count_m0", 64'(n_acks[0]), 64'd10);
    check_eq("t2_count_m1", 64'(n_acks[1]), 64'd10);
    step();

    // Write steering from master 1 with master 0 idle
    lat = 2;
    set_master(1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
    push_exp(1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
    rem[1] = 1; m_bus_en[1] = 1'b1;
    step();
    check_eq("t3_wr_en", 64'(wr_en), 64'd1);
    check_eq("t3_addr", 64'(addr), 64'h2000);
    check_eq("t3_wdata", 64'(wr_data), 64'h1234_5678);
    check_eq("t3_be", 64'(byte_en), 64'h3);
    drain("t3_drain", 20);
    step();

    // Reset while a write is pending
    resp_en = 1'b0;
    set_master(0, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 4'hF);
    rem[0] = 1; m_bus_en[0] = 1'b1;
    step();
    check_eq("t5_grant", 64'(grant), 64'd1);
    step();
    rst = 1'b1;
    step();
    check_eq("t5_bus_en", 64'(bus_en), 64'd0);
    check_eq("t5_wr_en", 64'(wr_en), 64'd0);
    check_eq("t5_addr", 64'(addr), 64'd0);
    check_eq("t5_wdata", 64'(wr_data), 64'd0);
    check_eq("t5_grant_rst", 64'(grant), 64'd0);
    check_eq("t5_m_ack", 64'(m_ack), 64'd0);
    rst = 1'b0; m_bus_en[0] = 1'b0; rem[0] = 0;
    resp_en = 1'b1; lat = 1;
    set_master(1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
    push_exp(1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
    rem[1] = 1; m_bus_en[1] = 1'b1;
    step();
    check_eq("t5_post_grant", 64'(grant), 64'd2);
    drain("t5_drain", 20);
    step();

`ifdef ARVI_ARB_LOCK_EN
    // Atomic read then write by master 0 stay indivisible against master 1
    m_atomic[0] = 1'b1;
    set_master(0, 1'b0, 32'h0000_0700, 32'h0, 4'hF);
    nxt_v[0] = 1'b1; nxt_wr[0] = 1'b1; nxt_addr[0] = 32'h0000_0704;
    nxt_wd[0] = 32'h0BAD_CAFE; nxt_be[0] = 4'hF;
    set_master(1, 1'b0, 32'h0000_0800, 32'h0, 4'hF);
    push_exp(0, 1'b0, 32'h0000_0700, 32'h0, 4'hF);
    push_exp(0, 1'b1, 32'h0000_0704, 32'h0BAD_CAFE, 4'hF);
    push_exp(1, 1'b0, 32'h0000_0800, 32'h0, 4'hF);
    rem[0] = 2; rem[1] = 1; m_bus_en = 2'b11;
    drain("t6_drain", 40);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single external memory bus between `N_MASTERS` hart bus masters in multi-core builds. Each hart's bus-master port connects on the upstream side. The arbiter drives one downstream bus-master port with the same signal set and protocol toward memory or the interconnect. It grants one master per transaction, steers the ack back to that master and broadcasts read data. With the lock feature compiled in, it also keeps atomic read-modify-write sequences indivisible.

## Interface
- `N_MASTERS`, default 2: number of upstream masters, range 2..8.
- `XLEN`, default `` `XLEN ``: data and address width.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_m_bus_en`  in  N_MASTERS  per-master request; held high until that master's ack.
- `i_m_wr_en`  in  N_MASTERS  per-master write strobe (1 = write).
- `i_m_addr`  in  N_MASTERS*XLEN  packed addresses; master i occupies bits [i*XLEN +: XLEN].
- `i_m_wr_data`  in  N_MASTERS*XLEN  packed write data, same packing as `i_m_addr`.
- `i_m_byte_en`  in  N_MASTERS*4  packed byte enables.
- `i_m_atomic`  in  N_MASTERS  lock request; only present with `ARVI_ARB_LOCK_EN`.
- `o_m_ack`  out  N_MASTERS  per-master ack, one-hot or zero.
- `o_m_rd_data`  out  XLEN  read data, broadcast to all masters; valid only with that master's ack.
- `o_bus_en`, `o_wr_en`  out  1  downstream request and write strobe.
- `o_addr`, `o_wr_data`  out  XLEN  downstream address and write data.
- `o_byte_en`  out  4  downstream byte enables.
- `i_ack`  in  1  downstream single-cycle completion pulse.
- `i_rd_data`  in  XLEN  downstream read data, valid with `i_ack`.
- `o_grant`  out  N_MASTERS  one-hot current owner, zero when idle; debug/perf observation.

## Operation
- FSM states: IDLE, BUSY, LOCKED (LOCKED exists only with `ARVI_ARB_LOCK_EN`).
- State is held in registers: the FSM state, the grant vector `gnt`, and a round-robin pointer `rr_ptr` of width clog2(N_MASTERS).
- IDLE:
  - If any `i_m_bus_en` bit is high, select the first requester at or after `rr_ptr`, wrapping modulo N_MASTERS.
  - Load `gnt` with that one-hot selection and go to BUSY.
  - If no request is present, stay in IDLE.
- BUSY:
  - Downstream outputs are muxed combinationally from the granted master's inputs, selected by `gnt`.
  - `o_m_ack[g] = i_ack`; `o_m_rd_data = i_rd_data` in every cycle.
  - On `i_ack`: set `rr_ptr = g+1` (wrapping), clear `gnt`, go to IDLE.
  - Protocol violation: if the granted master's `i_m_bus_en` falls before `i_ack`, clear `gnt` and go to IDLE without updating `rr_ptr`. Any later stray `i_ack` is ignored.
- When `gnt` is zero, all downstream outputs are 0 and `o_m_ack` is 0. An `i_ack` that arrives in IDLE is discarded.
- A master that has just been acked and re-requests in the next cycle competes normally. It has the lowest priority at that point because `rr_ptr` has moved past it.
- Fairness: with all masters requesting continuously, each master is served once in every N_MASTERS transactions.

## Timing
- Reset: state=IDLE, `gnt`=0, `rr_ptr`=0. Every output is 0 in the cycle after `i_rst` is sampled high.
- Reset mid-transaction aborts the grant. The downstream side must tolerate `o_bus_en` dropping.
- Grant latency: a request sampled in IDLE at cycle t drives `o_bus_en` from cycle t+1.
- Ack is combinational pass-through with zero added latency.
- Turnaround: each transaction costs one IDLE cycle after its ack. Peak throughput is therefore one transaction per (downstream latency + 2) cycles.
- `o_bus_en` stays high continuously from the grant until the cycle that contains `i_ack`, inclusive.

## Configuration
- `ARVI_ARB_LOCK_EN` defined:
  - The `i_m_atomic` port exists.
  - If the granted master has `i_m_atomic` high in its ack cycle, the FSM goes to LOCKED instead of IDLE. `gnt` is retained and `rr_ptr` is not updated.
  - LOCKED: if the owner has `i_m_bus_en` high, go to BUSY in the same grant, giving a zero-cycle rearbitration. If the owner has `i_m_atomic` low, update `rr_ptr` and go to IDLE.
  - In LOCKED, requests from other masters are held off indefinitely.
- `ARVI_ARB_LOCK_EN` undefined:
  - No `i_m_atomic` port and no LOCKED state.
  - Every ack returns the FSM to IDLE.

## Test plan
- Single master: master 0 issues a read to addr 0x100, downstream acks 3 cycles after `o_bus_en` with 0xDEADBEEF → `o_m_ack` = 01 in the ack cycle, `o_m_rd_data` = 0xDEADBEEF, `o_grant` = 0 in the following cycle.
- Contention: masters 0 and 1 both request continuously from reset, ack latency 1 → grant order 0,1,0,1; each transaction is 3 cycles; neither master is starved over 20 transactions.
- Write steering: master 1 writes 0x12345678 to 0x2000 with byte_en 0011 while master 0 is idle → downstream sees exactly those values and `o_wr_en` = 1; `o_m_ack[0]` never asserts.
- Abort/stray ack: granted master 1 drops `i_m_bus_en` before its ack, then `i_ack` pulses in IDLE → no `o_m_ack` bit asserts; the next grant goes to master 1 because `rr_ptr` is unchanged.
- Reset mid-BUSY: `i_rst` pulsed while a write is pending → all outputs are 0 next cycle; the first post-reset request from master 1 is granted, with `rr_ptr` = 0.
- Lock (with `ARVI_ARB_LOCK_EN`): master 0 performs an atomic read then a write with `i_m_atomic` = 1 while master 1 is requesting → both master 0 transactions complete back to back, then master 1 is granted.
